ysyx_23060203_ifu: RTL and testbench

- Instruction fetch unit: owns the architectural PC and fetches 32-bit instructions from instruction memory over an AXI-lite-style read channel (AR/R).
- Presents {inst, pc} to the decode stage through a valid/ready handshake.
- Accepts the next PC from the execute stage to start the next fetch.
- Producer end of the decoder's inst/pc input. Multicycle core, one instruction in flight.

---
 rtl/ysyx_23060203_ifu.sv | 119 +++++++++++
 tb/tb_ysyx_23060203_ifu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_ifu.sv
`default_nettype none
// ==========================================================================
// ysyx_23060203_ifu : PC owner and AXI-lite-style instruction fetch unit
// Rev 1.0
// ==========================================================================
module ysyx_23060203_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_araddr,
  output logic        imem_arvalid,
  input  logic        imem_arready,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  imem_rresp,
  input  logic        imem_rvalid,
  output logic        imem_rready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [1:0]  out_err,
  input  logic        next_valid,
  input  logic [31:0] next_pc
);

  typedef enum logic [1:0] {
    S_REQ      = 2'd0,
    S_RESP     = 2'd1,
    S_OUT      = 2'd2,
    S_WAIT_NPC = 2'd3
  } state_t;

  localparam logic [1:0] c_ERR_NONE  = 2'b00;
  localparam logic [1:0] c_ERR_FAULT = 2'b01;
  localparam logic [1:0] c_ERR_ALIGN = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [1:0]  err_q, err_d;
  logic        w_take_npc;

  // A new PC is accepted on an output handshake or while idling for it.
  always_comb begin
    w_take_npc = 1'b0;
    if (state_q == S_OUT)
      w_take_npc = out_ready && next_valid;
    else if (state_q == S_WAIT_NPC)
      w_take_npc = next_valid;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    err_d   = err_q;
    case (state_q)
      S_REQ: begin
        if (imem_arready) state_d = S_RESP;
      end
      S_RESP: begin
        if (imem_rvalid) begin
          state_d = S_OUT;
          if (imem_rresp == 2'b00) begin
            inst_d = imem_rdata;
            err_d  = c_ERR_NONE;
          end else begin
            inst_d = NOP_INST;
            err_d  = c_ERR_FAULT;
          end
        end
      end
      S_OUT: begin
        if (out_ready && !next_valid) state_d = S_WAIT_NPC;
      end
      default: begin
      end
    endcase

    // Misaligned targets never reach memory; a NOP is handed out directly.
    if (w_take_npc) begin
      pc_d = next_pc;
      if (next_pc[1:0] == 2'b00) begin
        state_d = S_REQ;
      end else begin
        state_d = S_OUT;
        inst_d  = NOP_INST;
        err_d   = c_ERR_ALIGN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      err_q   <= c_ERR_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  // REQ is the reset state, so the request is masked while reset is held.
  assign imem_araddr  = pc_q;
  assign imem_arvalid = (state_q == S_REQ) && !rst;
  assign imem_rready  = (state_q == S_RESP);
  assign out_valid    = (state_q == S_OUT);
  assign out_inst     = inst_q;
  assign out_pc       = pc_q;
  assign out_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_ifu.sv
`default_nettype none
// tb_ysyx_23060203_ifu : directed self-checking bench for the fetch unit
module tb_ysyx_23060203_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] imem_araddr;
  logic        imem_arvalid;
  logic        imem_arready;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rvalid;
  logic        imem_rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [1:0]  out_err;
  logic        next_valid;
  logic [31:0] next_pc;

  int n_cmp;
  int n_err;

  ysyx_23060203_ifu dut (
    .clk          (clk),
    .rst          (rst),
    .imem_araddr  (imem_araddr),
    .imem_arvalid (imem_arvalid),
    .imem_arready (imem_arready),
    .imem_rdata   (imem_rdata),
    .imem_rresp   (imem_rresp),
    .imem_rvalid  (imem_rvalid),
    .imem_rready  (imem_rready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_err      (out_err),
    .next_valid   (next_valid),
    .next_pc      (next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    imem_arready = 1'b0;
    imem_rdata   = 32'h0;
    imem_rresp   = 2'b00;
    imem_rvalid  = 1'b0;
    out_ready    = 1'b0;
    next_valid   = 1'b0;
    next_pc      = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_arvalid",  {31'b0, imem_arvalid}, 32'd0);
    chk("rst_rready",   {31'b0, imem_rready},  32'd0);
    chk("rst_outvalid", {31'b0, out_valid},    32'd0);
    chk("rst_inst",     out_inst,              32'h0000_0013);
    chk("rst_err",      {30'b0, out_err},      32'd0);
    chk("rst_pc",       out_pc,                32'h8000_0000);

    // basic fetch after release
    rst = 1'b0;
    #1;
    chk("t1_arvalid", {31'b0, imem_arvalid}, 32'd1);
    chk("t1_araddr",  imem_araddr,           32'h8000_0000);
    imem_arready = 1'b1;
    @(negedge clk);
    chk("t1_rready",  {31'b0, imem_rready},  32'd1);
    chk("t1_arv_off", {31'b0, imem_arvalid}, 32'd0);
    imem_arready = 1'b0;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'h0000_0297;
    @(negedge clk);
    imem_rvalid  = 1'b0;
    chk("t1_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_inst",  out_inst,           32'h0000_0297);
    chk("t1_pc",    out_pc,             32'h8000_0000);
    chk("t1_err",   {30'b0, out_err},   32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t1_wait_valid", {31'b0, out_valid},    32'd0);
    chk("t1_wait_arv",   {31'b0, imem_arvalid}, 32'd0);

    // WAIT_NPC -> sequential pc, with stalled AR and R channels
    next_valid = 1'b1;
    next_pc    = 32'h8000_0004;
    @(negedge clk);
    chk("t2_arvalid", {31'b0, imem_arvalid}, 32'd1);
    chk("t2_araddr",  imem_araddr,           32'h8000_0004);
    next_pc = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_arv_hold",  {31'b0, imem_arvalid}, 32'd1);
      chk("t2_addr_hold", imem_araddr,           32'h8000_0004);
    end
    next_valid   = 1'b0;
    imem_arready = 1'b1;
    @(negedge clk);
    imem_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_resp_wait", {31'b0, imem_rready}, 32'd1);
      chk("t2_no_valid",  {31'b0, out_valid},   32'd0);
      @(negedge clk);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0010_0093;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hFFFF_FFFF;
    chk("t2_valid", {31'b0, out_valid}, 32'd1);
    chk("t2_inst",  out_inst,           32'h0010_0093);
    chk("t2_pc",    out_pc,             32'h8000_0004);

    // output backpressure, then single-cycle next_pc
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_valid_hold", {31'b0, out_valid},    32'd1);
      chk("t3_inst_hold",  out_inst,              32'h0010_0093);
      chk("t3_pc_hold",    out_pc,                32'h8000_0004);
      chk("t3_err_hold",   {30'b0, out_err},      32'd0);
      chk("t3_no_ar",      {31'b0, imem_arvalid}, 32'd0);
    end
    out_ready  = 1'b1;
    next_valid = 1'b1;
    next_pc    = 32'h8000_0010;
    @(negedge clk);
    out_ready  = 1'b0;
    next_valid = 1'b0;
    chk("t3_arvalid", {31'b0, imem_arvalid}, 32'd1);
    chk("t3_araddr",  imem_araddr,           32'h8000_0010);
    chk("t3_valid_off", {31'b0, out_valid},  32'd0);

    // error response
    imem_arready = 1'b1;
    @(negedge clk);
    imem_arready = 1'b0;
    imem_rvalid  = 1'b1;
    imem_rresp   = 2'b10;
    imem_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid  = 1'b0;
    imem_rresp   = 2'b00;
    chk("t4_valid", {31'b0, out_valid}, 32'd1);
    chk("t4_inst",  out_inst,           32'h0000_0013);
    chk("t4_err",   {30'b0, out_err},   32'd1);
    chk("t4_pc",    out_pc,             32'h8000_0010);

    // misaligned next pc
    out_ready  = 1'b1;
    next_valid = 1'b1;
    next_pc    = 32'h8000_0006;
    @(negedge clk);
    out_ready  = 1'b0;
    next_valid = 1'b0;
    chk("t5_no_ar", {31'b0, imem_arvalid}, 32'd0);
    chk("t5_valid", {31'b0, out_valid},    32'd1);
    chk("t5_pc",    out_pc,                32'h8000_0006);
    chk("t5_inst",  out_inst,              32'h0000_0013);
    chk("t5_err",   {30'b0, out_err},      32'd2);
    out_ready  = 1'b1;
    next_valid = 1'b1;
    next_pc    = 32'h8000_0020;
    @(negedge clk);
    out_ready  = 1'b0;
    next_valid = 1'b0;
    chk("t5_recover_arv",  {31'b0, imem_arvalid}, 32'd1);
    chk("t5_recover_addr", imem_araddr,           32'h8000_0020);

    // reset while waiting for a response
    imem_arready = 1'b1;
    @(negedge clk);
    imem_arready = 1'b0;
    chk("t6_in_resp", {31'b0, imem_rready}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_rready", {31'b0, imem_rready},  32'd0);
    chk("t6_rst_arv",    {31'b0, imem_arvalid}, 32'd0);
    chk("t6_rst_addr",   imem_araddr,           32'h8000_0000);
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("t6_arvalid", {31'b0, imem_arvalid}, 32'd1);
    chk("t6_araddr",  imem_araddr,           32'h8000_0000);
    chk("t6_rready",  {31'b0, imem_rready},  32'd0);
    @(negedge clk);
    chk("t6_dropped",   {31'b0, out_valid},    32'd0);
    chk("t6_still_req", {31'b0, imem_arvalid}, 32'd1);
    imem_rvalid  = 1'b0;
    imem_arready = 1'b1;
    @(negedge clk);
    imem_arready = 1'b0;
    chk("t6_no_valid", {31'b0, out_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0517;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t6_valid", {31'b0, out_valid}, 32'd1);
    chk("t6_inst",  out_inst,           32'h0000_0517);
    chk("t6_pc",    out_pc,             32'h8000_0000);
    chk("t6_err",   {30'b0, out_err},   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
